// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM request front-end.
package sram_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding captured SRAM read data until the consumer takes it.
module sram_rsp_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for the 32x16 SRAM: valid/ready request channel, buffered
// read responses, and a clear engine that zeroes every word.
module sram_req_ctrl #(
  parameter int ADDR_W    = sram_pkg::ADDR_W,
  parameter int DATA_W    = sram_pkg::DATA_W,
  parameter int MEM_WORDS = sram_pkg::MEM_WORDS,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  import sram_pkg::*;

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  ctrl_state_t       state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              rd_pending_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  count_s;
  logic [OCC_W-1:0]  occ_s;
  logic              pop_s;
  logic              ready_s;
  logic              accept_s;

  // A read in flight already owns a FIFO slot, so it counts toward occupancy.
  assign rsp_valid = (count_s != {CNT_W{1'b0}});
  assign pop_s     = rsp_valid && rsp_ready;
  assign occ_s     = OCC_W'(count_s) + OCC_W'(rd_pending_r) - OCC_W'(pop_s);
  assign ready_s   = (state_r == IDLE) && !clear_start && (occ_s < OCC_W'(RSP_DEPTH));
  assign req_ready = rst && ready_s;
  assign accept_s  = req_valid && ready_s;

  assign clear_busy = busy_r;
  assign clear_done = done_r;

  // SRAM pin mux: the sweep owns the pins while clearing.
  always_comb begin
    mem_addr  = req_addr;
    mem_din   = req_wdata;
    mem_wr_en = req_valid && req_ready && req_write;
    case (state_r)
      CLEAR: begin
        mem_addr  = clr_cnt_r;
        mem_din   = {DATA_W{1'b0}};
        mem_wr_en = 1'b1;
      end
      IDLE: begin
        mem_addr  = req_addr;
        mem_din   = req_wdata;
        mem_wr_en = req_valid && req_ready && req_write;
      end
      default: begin
        mem_wr_en = 1'b0;
      end
    endcase
  end

  // Marks the cycle in which the SRAM presents data for an accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= accept_s && !req_write;
    end
  end

  // Clear sweep FSM with registered busy/done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      clr_cnt_r <= {ADDR_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r    <= 1'b0;
          clr_cnt_r <= {ADDR_W{1'b0}};
          if (clear_start) begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            clr_cnt_r <= {ADDR_W{1'b0}};
          end else begin
            state_r   <= CLEAR;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1'b1);
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          clr_cnt_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending_r),
    .push_data (mem_dout),
    .pop       (pop_s),
    .pop_data  (rsp_rdata),
    .count     (count_s)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench: SRAM model, transaction-level reference model, directed tests.
module tb_sram_req_ctrl;

  localparam int MW    = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic        clear_done;
  logic [4:0]  mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(5), .DATA_W(16), .MEM_WORDS(MW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // SRAM: registered dout, updated only on read cycles.
  logic [15:0] sram [32];
  initial begin
    for (int i = 0; i < 32; i++) sram[i] = 16'h0000;
    mem_dout = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_din;
    else           mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: shadow memory, queue of accepted reads, clear start cycle.
  typedef struct { logic [15:0] d; int avail; } rsp_t;
  rsp_t        q[$];
  logic [15:0] shadow [32];
  logic [15:0] popped[$];
  int          cyc = 0;
  int          cs  = -1000;
  logic        m_busy, m_done, m_valid, m_pop, m_ready;

  initial for (int i = 0; i < 32; i++) shadow[i] = 16'h0000;

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready && rst) popped.push_back(rsp_rdata);
    if (!rst) begin
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
      chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
      chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      q.delete();
      cs = -1000;
    end else begin
      m_busy  = (cyc >= cs + 1) && (cyc <= cs + MW);
      m_done  = (cyc == cs + MW + 1);
      m_valid = (q.size() > 0) && (q[0].avail <= cyc);
      m_pop   = m_valid && rsp_ready;
      m_ready = !m_busy && !clear_start && ((q.size() - (m_pop ? 1 : 0)) < DEPTH);
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("clear_busy", {31'd0, clear_busy}, {31'd0, m_busy});
      chk("clear_done", {31'd0, clear_done}, {31'd0, m_done});
      if (m_valid) chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, q[0].d});
      if (m_busy) begin
        chk("clr_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("clr_din", {16'd0, mem_din}, 32'd0);
        chk("clr_addr", {27'd0, mem_addr}, 32'(cyc - cs - 1) & 32'h1f);
      end else begin
        chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, req_valid && m_ready && req_write});
        chk("mem_addr", {27'd0, mem_addr}, {27'd0, req_addr});
        chk("mem_din", {16'd0, mem_din}, {16'd0, req_wdata});
      end
      if (req_valid && m_ready) begin
        if (req_write) shadow[req_addr] = req_wdata;
        else           q.push_back('{shadow[req_addr], cyc + 2});
      end
      if (m_pop) void'(q.pop_front());
      if (clear_start && !m_busy) begin
        cs = cyc;
        for (int i = 0; i < 32; i++) shadow[i] = 16'h0000;
      end
    end
    cyc++;
  end

  // Holds a request until accepted; returns cycles spent (1 = no bubble).
  task automatic do_req(input logic w, input logic [4:0] a, input logic [15:0] d, output int it);
    logic got;
    got = 1'b0;
    it  = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!got && it < 100) begin
      @(negedge clk);
      got = req_ready;
      it++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=not_accepted expected=accepted addr=%0d", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int it, n0, bc, dc;
  logic seen;

  initial begin
    idle(3);
    rst = 1'b1;
    idle(1);

    // Write then read: response exactly two cycles after the accept.
    do_req(1'b1, 5'd3, 16'hBEEF, it);
    do_req(1'b0, 5'd3, 16'h0000, it);
    @(negedge clk);
    chk("wr_rd_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("wr_rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rd_data", {16'd0, rsp_rdata}, 32'h0000BEEF);
    @(posedge clk); #1;

    // Back-to-back reads with no bubbles, data in order.
    for (int i = 0; i < 8; i++) do_req(1'b1, 5'(i), 16'h1000 + 16'(i), it);
    n0 = popped.size();
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 5'(i), 16'h0000, it);
      chk("b2b_bubble", it, 32'd1);
    end
    idle(4);
    chk("b2b_count", popped.size() - n0, 32'd8);
    for (int i = 0; i < 8 && n0 + i < popped.size(); i++)
      chk("b2b_data", {16'd0, popped[n0+i]}, 32'h1000 + 32'(i));

    // Backpressure: two reads outstanding, then stall until released.
    for (int i = 8; i < 12; i++) do_req(1'b1, 5'(i), 16'hA000 + 16'(i), it);
    rsp_ready = 1'b0;
    n0 = popped.size();
    do_req(1'b0, 5'd8, 16'h0000, it);
    chk("bp_acc0", it, 32'd1);
    do_req(1'b0, 5'd9, 16'h0000, it);
    chk("bp_acc1", it, 32'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_req(1'b0, 5'd10, 16'h0000, it);
    do_req(1'b0, 5'd11, 16'h0000, it);
    idle(5);
    chk("bp_count", popped.size() - n0, 32'd4);
    for (int i = 0; i < 4 && n0 + i < popped.size(); i++)
      chk("bp_data", {16'd0, popped[n0+i]}, 32'hA008 + 32'(i));

    // Clear sweep zeroes the first and last words.
    do_req(1'b1, 5'd0, 16'h1234, it);
    do_req(1'b1, 5'd31, 16'h1234, it);
    do_req(1'b1, 5'd5, 16'h5555, it);
    clear_start = 1'b1;
    idle(1);
    clear_start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bc += int'(clear_busy);
      dc += int'(clear_done);
    end
    @(posedge clk); #1;
    chk("clr_busy_cycles", bc, 32'd32);
    chk("clr_done_pulses", dc, 32'd1);
    n0 = popped.size();
    do_req(1'b0, 5'd0, 16'h0000, it);
    do_req(1'b0, 5'd31, 16'h0000, it);
    idle(4);
    chk("clr_rd_count", popped.size() - n0, 32'd2);
    for (int i = 0; i < 2 && n0 + i < popped.size(); i++)
      chk("clr_rd_data", {16'd0, popped[n0+i]}, 32'h0000);

    // Collision: clear wins, read reissued after completion.
    clear_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    @(negedge clk);
    chk("coll_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    req_valid = 1'b0;
    n0 = popped.size();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = clear_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL coll_done_timeout actual=no_done expected=done");
    end
    chk("coll_no_rsp", popped.size() - n0, 32'd0);
    @(posedge clk); #1;
    do_req(1'b0, 5'd5, 16'h0000, it);
    idle(4);
    chk("coll_rsp_count", popped.size() - n0, 32'd1);
    if (popped.size() > n0) chk("coll_rsp_data", {16'd0, popped[n0]}, 32'h0000);

    // Reset in the middle of a sweep with a buffered response.
    do_req(1'b1, 5'd7, 16'h7777, it);
    rsp_ready = 1'b0;
    do_req(1'b0, 5'd7, 16'h0000, it);
    clear_start = 1'b1;
    idle(1);
    clear_start = 1'b0;
    idle(9);
    @(negedge clk);
    chk("mid_buf_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mid_buf_data", {16'd0, rsp_rdata}, 32'h7777);
    chk("mid_busy", {31'd0, clear_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    idle(2);
    rst = 1'b1;
    rsp_ready = 1'b1;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dc += int'(clear_done);
    end
    chk("mid_no_done", dc, 32'd0);
    chk("mid_post_valid", {31'd0, rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request front-end for the 32×16 synchronous `SRAM` block. It sits directly upstream of the SRAM and drives its `addr`/`wr_en`/`din` pins from a valid/ready request channel. It captures the SRAM's registered `dout` into a small response FIFO behind a valid/ready response channel. It also provides a clear engine that zeroes every SRAM word on command.

## Interface
Parameters:
- `ADDR_W`, 5, SRAM address width
- `DATA_W`, 16, SRAM data width
- `MEM_WORDS`, 32, number of words swept by the clear engine
- `RSP_DEPTH`, 2, response FIFO entries (≥2)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  read data available
- `rsp_ready`  in  1  consumer takes read data
- `rsp_rdata`  out  DATA_W  read data, in request order
- `clear_start`  in  1  one-cycle pulse; starts a clear sweep
- `clear_busy`  out  1  sweep in progress
- `clear_done`  out  1  one-cycle pulse on sweep completion
- `mem_addr`  out  ADDR_W  to SRAM `addr`
- `mem_wr_en`  out  1  to SRAM `wr_en`
- `mem_din`  out  DATA_W  to SRAM `din`
- `mem_dout`  in  DATA_W  from SRAM `dout`

## Operation
- FSM states are `IDLE` and `CLEAR`. The FSM resets to `IDLE`.
- **Reset values:** `req_ready`=0 during reset, `rsp_valid`=0, FIFO count=0, `rd_pending`=0, `clear_busy`=0, `clear_done`=0, clear counter=0.
- **SRAM pins:** combinational from the current cycle.
  - In `CLEAR`: `mem_addr`=clear counter, `mem_wr_en`=1, `mem_din`=0.
  - In `IDLE`: `mem_addr`=`req_addr`, `mem_din`=`req_wdata`, `mem_wr_en`=`req_valid && req_ready && req_write`.
- **Request ready rule:** `req_ready` = (state==`IDLE`) && !`clear_start` && (count + `rd_pending` − pop < RSP_DEPTH), where pop = `rsp_valid && rsp_ready`. The same rule applies to writes.
- **Read accept:** sets `rd_pending`. On the next edge, `mem_dout` is pushed into the FIFO and `rd_pending` clears unless another read is accepted that cycle.
- **Writes:** complete at the acceptance edge and produce no response.
- **Response channel:** `rsp_valid` = (count≠0). `rsp_rdata` = FIFO head. Push and pop in the same cycle leave the count unchanged.
- **Clear sweep:**
  - `clear_start` in `IDLE` moves the FSM to `CLEAR` with counter 0.
  - The sweep writes addresses 0..MEM_WORDS−1, one per cycle.
  - After the cycle writing address MEM_WORDS−1, the FSM returns to `IDLE` and `clear_done` pulses for one cycle.
  - `clear_start` is ignored while in `CLEAR`.
- **Boundary cases:**
  - If `clear_start` and `req_valid` arrive in the same cycle, the clear wins and the request is not accepted.
  - A read pending at clear entry is still captured at the first `CLEAR` edge, because SRAM write cycles do not update `dout`.
  - Addresses wrap modulo 2^ADDR_W. No range check is made.
  - Reset mid-sweep aborts the sweep with no `clear_done`; SRAM contents are then undefined.
  - Reset mid-read discards pending and buffered responses.

## Timing
- A read accepted in cycle t gives `rsp_valid` high in cycle t+2 (FIFO previously empty).
- Sustained throughput is one request per cycle while `rsp_ready`=1.
- With `rsp_ready`=0, at most RSP_DEPTH reads are outstanding. After that, `req_ready` drops for all requests.
- A clear occupies MEM_WORDS cycles with `clear_busy`=1, then `clear_done` asserts in cycle MEM_WORDS+1 after the start cycle. `req_ready` returns high that same cycle.
- The only combinational paths are `clear_start`/`rsp_ready` → `req_ready` and `req_*` → `mem_*`. There is no path from `req_valid` to `req_ready`.

## Structure
- Package `sram_pkg` holds:
  - `ADDR_W`, `DATA_W`, `MEM_WORDS` constants
  - the `ctrl_state_t` enum {`IDLE`, `CLEAR`}
- Sub-module `sram_rsp_fifo`: synchronous FIFO with parameters DATA_W and DEPTH, push/pop ports, and count output. It uses the same clock/reset.
- Top level contains the FSM, clear counter, `rd_pending` flop, and ready logic.

## Test plan
- **Write then read:** write 0xBEEF to addr 3, then read addr 3 → `rsp_rdata`=0xBEEF with `rsp_valid` exactly two cycles after the read accept.
- **Back-to-back reads:** reads of addrs 0..7 on consecutive cycles with `rsp_ready`=1 → no `req_ready` bubbles; data returned in order.
- **Backpressure:** hold `rsp_ready`=0 and issue 4 reads → exactly 2 accepted, then `req_ready`=0. Release `rsp_ready` → remaining reads accepted and all 4 responses returned in order.
- **Clear:** write 0x1234 to addrs 0 and 31, pulse `clear_start` → `clear_busy` high for 32 cycles and `clear_done` pulses once. Subsequent reads of addrs 0 and 31 return 0x0000.
- **Collision:** `clear_start` with a `req_valid` read in the same cycle → request not accepted and no response. The read is reissued and accepted after `clear_done`.
- **Reset mid-operation:** assert `rst` low at clear cycle 10 with one response buffered → all outputs return to reset values and no `clear_done` pulse occurs.
